pipe_stage_elastic: RTL
=======================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID … MEM/WB); one instance replaces a bank of per-field flops.
- Carries a control bundle and a data bundle across one pipeline boundary with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble insertion.
- Downstream stalls are absorbed without a combinational ready path from downstream to upstream.

Parameters:
- CTRL_W, 8: width of the control bundle (mem_to_reg, write_reg, pcs, halt, …); forced to zero in bubbles.
- DATA_W, 64: width of the data bundle (alu_out, mem_data, pc_nxt, reg ids, …); not cleared on bubble.
- CTRL_RST, {CTRL_W{1'b0}}: value loaded into control registers on rst/flush.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept a beat; registered, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  synchronous kill of all held beats (branch mispredict / exception).
- out_valid  out  1  beat presented downstream; equals main_valid.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  control bundle; equals CTRL_RST whenever out_valid=0.
- out_data  out  DATA_W  data bundle of the head beat.
- occupancy  out  2  held beats, 0..2.

Behaviour:
- Storage: main entry (main_valid, main_ctrl, main_data) and skid entry (skid_valid, skid_ctrl, skid_data).
- Reset: rst=1 at a clock edge clears main_valid and skid_valid, loads both ctrl registers with CTRL_RST, and zeroes both data registers.
  - After reset: in_ready=1, out_valid=0, out_ctrl=CTRL_RST, out_data=0, occupancy=0.
  - rst asserted mid-operation discards all held beats.
- Accept: acc = in_valid & in_ready. Pop: pop = out_valid & out_ready.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N when the stage was empty.
- Transitions, evaluated per edge with flush=0:
  - Empty + acc: main <= in.
  - Main only, pop & acc: main <= in.
  - Main only, pop & !acc: main_valid <= 0.
  - Main only, !pop & acc: skid <= in (in_ready falls next cycle).
  - Main only, !pop & !acc: hold.
  - Full, pop: main <= skid and skid_valid <= 0. acc is impossible because in_ready=0.
  - Full, !pop: hold; in_ready stays 0.
- Ordering: beats leave strictly in acceptance order. No beat is ever dropped or duplicated.
- Flush has priority over accept and pop:
  - Clears both valid bits and loads CTRL_RST into both ctrl registers.
  - Data registers keep their values.
  - A beat offered in the same cycle is dropped, even though in_ready was 1.
  - The downstream may still see pop=1 in the flush cycle; that beat counts as delivered.
- Priority: rst > flush > normal transitions.
- Bubble: out_ctrl is combinationally gated to CTRL_RST when out_valid=0. Downstream write enables are therefore inactive without needing to check valid.
- occupancy = main_valid + skid_valid; skid_valid=1 implies main_valid=1 (invariant, assert in bench).
- No combinational path from out_ready to in_ready.
- Throughput: 1 beat/cycle when out_ready is held high.

Optional Feature:
- Macro: PIPE_STAGE_STAT_EN.
- When defined:
  - Adds output stall_cnt (16 bits) counting cycles with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF; cleared by rst, not by flush.
  - Adds output drop_cnt (8 bits) counting flushes with occupancy≠0; saturates at 8'hFF; cleared by rst.
- When undefined: neither port nor its counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_ctrl=8'hFF -> in_ready=1, out_valid=0, out_ctrl=8'h00, out_data=0, occupancy=0.
- Streaming: out_ready=1, push 10 beats with data=0..9 back-to-back -> out_data 0..9 on consecutive cycles, 1 cycle behind input, in_ready constantly 1.
- Backpressure: out_ready=0, push 8'hA1 then 8'hA2 -> occupancy=2, in_ready=0. Raise out_ready -> A1 then A2 delivered in order, in_ready=1 one cycle after the skid drains.
- Flush while full: occupancy=2, assert flush with in_valid=1 and new data 8'h55 -> next cycle occupancy=0, out_valid=0, out_ctrl=CTRL_RST; 8'h55 is never delivered.
- Random: in_valid/out_ready randomised at 50% for 10k cycles against a scoreboard -> no loss, duplication or reordering; the skid_valid→main_valid invariant holds.
- With PIPE_STAGE_STAT_EN: hold out_ready=0 for 300 cycles with a beat present -> stall_cnt=300. Flush with occupancy=1 -> drop_cnt=1.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline boundary: control + data bundle, valid/ready handshake, 2-entry skid, flush, bubbles.
// Optional PIPE_STAGE_STAT_EN adds stall_cnt / drop_cnt statistics outputs.
module pipe_stage_elastic #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 64,
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_STAT_EN
  output logic [15:0]       stall_cnt,
  output logic [7:0]        drop_cnt,
`endif
  output logic [1:0]        occupancy
);

  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_acc;
  logic w_pop;

  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_valid ? r_main_ctrl : CTRL_RST;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  assign w_acc = in_valid & ~r_skid_valid;
  assign w_pop = r_main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= CTRL_RST;
      r_main_data  <= {DATA_W{1'b0}};
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= CTRL_RST;
      r_skid_data  <= {DATA_W{1'b0}};
    end else if (flush) begin
      // data registers deliberately keep their contents
      r_main_valid <= 1'b0;
      r_main_ctrl  <= CTRL_RST;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= CTRL_RST;
    end else if (!r_main_valid) begin
      if (w_acc) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= in_ctrl;
        r_main_data  <= in_data;
      end
    end else if (!r_skid_valid) begin
      if (w_pop && w_acc) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_pop) begin
        r_main_valid <= 1'b0;
      end else if (w_acc) begin
        r_skid_valid <= 1'b1;
        r_skid_ctrl  <= in_ctrl;
        r_skid_data  <= in_data;
      end
    end else if (w_pop) begin
      r_main_ctrl  <= r_skid_ctrl;
      r_main_data  <= r_skid_data;
      r_skid_valid <= 1'b0;
    end
  end

`ifdef PIPE_STAGE_STAT_EN
  logic [15:0] r_stall_cnt;
  logic [7:0]  r_drop_cnt;

  assign stall_cnt = r_stall_cnt;
  assign drop_cnt  = r_drop_cnt;

  // saturating statistics; flush does not clear them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_drop_cnt  <= 8'd0;
    end else begin
      if (r_main_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush && r_main_valid && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`endif

endmodule
